// File: rtl/alu_mc_if.sv
// Issue/result bundle between the EX-stage control unit (master) and the multi-cycle ALU (slave).
interface alu_mc_if #(
    parameter int WIDTH = 64
) ();
    logic             start;
    logic [3:0]       aluControl;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] aluOut;
    logic             zero;
    logic             aluResult;

    modport master (
        output start, aluControl, X, Y,
        input  busy, done, aluOut, zero, aluResult
    );

    modport slave (
        input  start, aluControl, X, Y,
        output busy, done, aluOut, zero, aluResult
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-cycle logic/shift/compare ops plus an iterative shift-add multiplier.
// Optional restoring unsigned divider (DIVU/REMU) enabled by defining ALU_MC_DIVIDER_EN.
module alu_mc #(
    parameter int WIDTH = 64
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = SHAMT_W + 1;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_SLL   = 4'd4;
    localparam logic [3:0] OP_SRL   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
`ifdef ALU_MC_DIVIDER_EN
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   alu_out;
    logic               busy_c;
    logic               done_c;
    logic               is_mul;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

`ifdef ALU_MC_DIVIDER_EN
    logic [WIDTH-1:0]   b_q;
    logic               is_div;
    logic               y_zero;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
`endif

    function automatic logic [WIDTH-1:0] alu_single(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [SHAMT_W-1:0]      sh;
        logic [WIDTH-1:0]        r;
        sa = a;
        sb = b;
        sh = b[SHAMT_W-1:0];
        r  = '0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SUB:  r = a - b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SRA:  r = sa >>> sh;
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign is_mul = (bus.aluControl == OP_MUL) || (bus.aluControl == OP_MULHU);

    // Multiplier keeps the multiplier operand in the low half of acc and retires one bit per cycle.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (a_q & {WIDTH{acc[0]}})};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

`ifdef ALU_MC_DIVIDER_EN
    assign is_div = (bus.aluControl == OP_DIVU) || (bus.aluControl == OP_REMU);
    assign y_zero = (bus.Y == '0);

    // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
`endif

    always_comb begin
        state_next = state;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (is_mul)
                        state_next = MUL;
`ifdef ALU_MC_DIVIDER_EN
                    else if (is_div && !y_zero)
                        state_next = DIV;
`endif
                    else
                        state_next = DONE;
                end
            end
            MUL: begin
                busy_c = 1'b1;
                if (cnt == CNT_ONE)
                    state_next = DONE;
            end
            DIV: begin
`ifdef ALU_MC_DIVIDER_EN
                busy_c = 1'b1;
                if (cnt == CNT_ONE)
                    state_next = DONE;
`else
                state_next = IDLE;
`endif
            end
            DONE: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            acc     <= '0;
            cnt     <= '0;
            alu_out <= '0;
`ifdef ALU_MC_DIVIDER_EN
            b_q     <= '0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.aluControl;
                        a_q  <= bus.X;
                        cnt  <= CNT_INIT;
                        if (is_mul)
                            acc <= {{WIDTH{1'b0}}, bus.Y};
`ifdef ALU_MC_DIVIDER_EN
                        else if (is_div) begin
                            b_q <= bus.Y;
                            acc <= {{WIDTH{1'b0}}, bus.X};
                            // Divide by zero finishes immediately with the RISC-V defined results.
                            if (y_zero)
                                alu_out <= (bus.aluControl == OP_DIVU) ? {WIDTH{1'b1}} : bus.X;
                        end
`endif
                        else
                            alu_out <= alu_single(bus.aluControl, bus.X, bus.Y);
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE)
                        alu_out <= (op_q == OP_MULHU) ? mul_next[2*WIDTH-1:WIDTH]
                                                      : mul_next[WIDTH-1:0];
                end
`ifdef ALU_MC_DIVIDER_EN
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE)
                        alu_out <= (op_q == OP_REMU) ? div_next[2*WIDTH-1:WIDTH]
                                                     : div_next[WIDTH-1:0];
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.aluOut    = alu_out;
    assign bus.zero      = (alu_out == '0);
    assign bus.aluResult = alu_out[0];
endmodule
